mips_multicycle_ctrl: RTL and testbench

Control FSM that sequences a multicycle MIPS datapath built on the existing ALU, register file and PC blocks with one shared instruction/data memory. Decodes op/funct, issues per-state mux selects and write enables, and stalls on a memory ready handshake. Flags unsupported instructions and memory timeouts. Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.

---
 rtl/mips_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Control FSM for a multicycle MIPS datapath. One shared instruction/data
//   memory, so instruction fetch and data access are separate states. Every
//   memory state stalls on mem_ready. A timeout counter aborts a stalled
//   access, and unsupported opcodes or functs are flagged.
//   Supported instructions: lw, sw, add/sub/and/or/slt, beq, addi, j.
//
// Parameters
//   WAIT_LIMIT : max stalled cycles in a memory state before abort (0 = never)
//   CNT_W      : wait counter width, must hold WAIT_LIMIT
//
// Ports
//   clk, reset          : clock (rising edge), async active-high reset
//   op, funct           : opcode / function fields from the instruction reg
//   zero                : ALU zero flag (beq)
//   mem_ready           : memory finishes the current access this cycle
//   memwrite, irwrite,
//   pcen, regwrite      : write enables (forced low while reset is high)
//   iord, regdst,
//   memtoreg, alusrca,
//   alusrcb, pcsrc      : datapath mux selects
//   alucontrol          : ALU operation
//   illegal_op, mem_err : one-cycle error pulses
//   state               : current state code (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;

    logic       w_mem_st;
    logic       w_timeout;
    logic       w_funct_ok;
    logic [2:0] w_alu_rt;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_regwrite;
    logic       w_illegal;

    // R-type funct decode, shared by DECODE (legality) and EXECUTE (ALU op)
    always_comb begin
        w_funct_ok = 1'b1;
        w_alu_rt   = ALU_ADD;
        case (funct)
            FN_ADD:  w_alu_rt = ALU_ADD;
            FN_SUB:  w_alu_rt = ALU_SUB;
            FN_AND:  w_alu_rt = ALU_AND;
            FN_OR:   w_alu_rt = ALU_OR;
            FN_SLT:  w_alu_rt = ALU_SLT;
            default: w_funct_ok = 1'b0;
        endcase
    end

    // A stalled memory access aborts once the counter has reached the limit.
    // A ready in the limit cycle still completes the access.
    always_comb begin
        w_mem_st  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_timeout = (WAIT_LIMIT != 0) && w_mem_st && !mem_ready
                    && (r_cnt >= CNT_W'(WAIT_LIMIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Counting only happens while the FSM stays put, so clearing
            // otherwise covers both state changes and a timeout abort.
            if (w_mem_st && !mem_ready && !w_timeout) begin
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (r_state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                w_irwrite  = mem_ready;
                w_pcwrite  = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RT: begin
                        w_next    = w_funct_ok ? S_EXECUTE : S_FETCH;
                        w_illegal = !w_funct_ok;
                    end
                    OP_BEQ:  w_next = S_BEQ;
                    OP_ADDI: w_next = S_ADDIEXEC;
                    OP_J:    w_next = S_JUMP;
                    default: w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                if (op == OP_LW)      w_next = S_MEMRD;
                else if (op == OP_SW) w_next = S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready)      w_next = S_MEMWB;
                else if (!w_timeout) w_next = S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = !w_timeout;
                if (!mem_ready && !w_timeout) w_next = S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_alu_rt;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                w_next     = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks every write so nothing lands while the FSM is held.
    assign memwrite   = !reset && w_memwrite;
    assign irwrite    = !reset && w_irwrite;
    assign pcen       = !reset && (w_pcwrite || (w_branch && zero));
    assign regwrite   = !reset && w_regwrite;
    assign illegal_op = !reset && w_illegal;
    assign mem_err    = !reset && w_timeout;
    assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;
    localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111, A_OR = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op, mem_err;
    logic [3:0] state;

    typedef struct packed {
        logic       memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op, mem_err;
    } out_t;

    typedef struct {
        string      tag;
        logic [5:0] op, funct;
        logic       zero, rdy;
        logic [3:0] st;
        out_t       o;
    } ent_t;

    ent_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    out_t act;

    assign act = {memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, alucontrol, illegal_op, mem_err};

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
    );

    // Expected outputs per state, straight from the state table.
    function automatic out_t o_fetch(logic rdy);
        out_t o = '0; o.alusrcb = 2'b01; o.alucontrol = A_ADD; o.irwrite = rdy; o.pcen = rdy; return o;
    endfunction
    function automatic out_t o_decode();
        out_t o = '0; o.alusrcb = 2'b11; o.alucontrol = A_ADD; return o;
    endfunction
    function automatic out_t o_memadr();
        out_t o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = A_ADD; return o;
    endfunction
    function automatic out_t o_memrd();
        out_t o = '0; o.iord = 1'b1; return o;
    endfunction
    function automatic out_t o_memwb();
        out_t o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1; return o;
    endfunction
    function automatic out_t o_memwr(logic en);
        out_t o = '0; o.iord = 1'b1; o.memwrite = en; return o;
    endfunction
    function automatic out_t o_exec(logic [2:0] alu);
        out_t o = '0; o.alusrca = 1'b1; o.alucontrol = alu; return o;
    endfunction
    function automatic out_t o_aluwb();
        out_t o = '0; o.regdst = 1'b1; o.regwrite = 1'b1; return o;
    endfunction
    function automatic out_t o_beq(logic z);
        out_t o = '0; o.alusrca = 1'b1; o.alucontrol = A_SUB; o.pcsrc = 2'b01; o.pcen = z; return o;
    endfunction
    function automatic out_t o_addiwb();
        out_t o = '0; o.regwrite = 1'b1; return o;
    endfunction
    function automatic out_t o_jump();
        out_t o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1; return o;
    endfunction
    function automatic out_t with_err(out_t i);
        out_t o = i; o.mem_err = 1'b1; return o;
    endfunction
    function automatic out_t with_ill(out_t i);
        out_t o = i; o.illegal_op = 1'b1; return o;
    endfunction

    task automatic check(string tag, logic [3:0] st_exp, out_t o_exp);
        n_chk++;
        assert (state === st_exp) n_pass++;
        else $error("FAIL %s state: got %0d expected %0d", tag, state, st_exp);
        n_chk++;
        assert (act === o_exp) n_pass++;
        else $error("FAIL %s outputs: got %05h expected %05h", tag, act, o_exp);
    endtask

    task automatic push(string tag, logic [5:0] o_p, logic [5:0] f_p, logic z, logic rdy,
                        logic [3:0] st, out_t o);
        ent_t e;
        e.tag = tag; e.op = o_p; e.funct = f_p; e.zero = z; e.rdy = rdy; e.st = st; e.o = o;
        sb.push_back(e);
    endtask

    // FETCH (ready) followed by DECODE for a legal instruction
    task automatic fd(string tag, logic [5:0] o_p, logic [5:0] f_p);
        push({tag, "_f"}, o_p, f_p, 1'b0, 1'b1, 4'd0, o_fetch(1'b1));
        push({tag, "_d"}, o_p, f_p, 1'b0, 1'b1, 4'd1, o_decode());
    endtask

    // Pop each expected cycle: drive its inputs, let outputs settle, compare,
    // then advance to the next falling edge (one rising edge in between).
    task automatic drain();
        ent_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            op = e.op; funct = e.funct; zero = e.zero; mem_ready = e.rdy;
            #1;
            check(e.tag, e.st, e.o);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; op = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        check("reset", 4'd0, o_fetch(1'b0));
        @(negedge clk);
        reset = 1'b0;

        // lw, ready high: 5 cycles
        fd("lw", LW, 6'd0);
        push("lw_adr", LW, 6'd0, 1'b0, 1'b1, 4'd2, o_memadr());
        push("lw_rd",  LW, 6'd0, 1'b0, 1'b1, 4'd3, o_memrd());
        push("lw_wb",  LW, 6'd0, 1'b0, 1'b1, 4'd4, o_memwb());
        // slt
        fd("slt", RT, 6'b101010);
        push("slt_ex", RT, 6'b101010, 1'b0, 1'b1, 4'd6, o_exec(A_SLT));
        push("slt_wb", RT, 6'b101010, 1'b0, 1'b1, 4'd7, o_aluwb());
        // sub, or
        fd("sub", RT, 6'b100010);
        push("sub_ex", RT, 6'b100010, 1'b0, 1'b1, 4'd6, o_exec(A_SUB));
        push("sub_wb", RT, 6'b100010, 1'b0, 1'b1, 4'd7, o_aluwb());
        fd("or", RT, 6'b100101);
        push("or_ex", RT, 6'b100101, 1'b0, 1'b1, 4'd6, o_exec(A_OR));
        push("or_wb", RT, 6'b100101, 1'b0, 1'b1, 4'd7, o_aluwb());
        // beq taken / not taken
        fd("beq1", BQ, 6'd0);
        push("beq1_b", BQ, 6'd0, 1'b1, 1'b1, 4'd8, o_beq(1'b1));
        fd("beq0", BQ, 6'd0);
        push("beq0_b", BQ, 6'd0, 1'b0, 1'b1, 4'd8, o_beq(1'b0));
        // sw with 3 stall cycles: memwrite held 4 cycles
        fd("sw", SW, 6'd0);
        push("sw_adr", SW, 6'd0, 1'b0, 1'b1, 4'd2, o_memadr());
        for (int i = 0; i < 3; i++)
            push("sw_wait", SW, 6'd0, 1'b0, 1'b0, 4'd5, o_memwr(1'b1));
        push("sw_done", SW, 6'd0, 1'b0, 1'b1, 4'd5, o_memwr(1'b1));
        // addi, j
        fd("addi", AI, 6'd0);
        push("addi_ex", AI, 6'd0, 1'b0, 1'b1, 4'd9, o_memadr());
        push("addi_wb", AI, 6'd0, 1'b0, 1'b1, 4'd10, o_addiwb());
        fd("j", JJ, 6'd0);
        push("j_j", JJ, 6'd0, 1'b0, 1'b1, 4'd11, o_jump());
        // illegal op and illegal funct: pulse in DECODE, back to FETCH
        push("ill_f", 6'b111111, 6'd0, 1'b0, 1'b1, 4'd0, o_fetch(1'b1));
        push("ill_d", 6'b111111, 6'd0, 1'b0, 1'b1, 4'd1, with_ill(o_decode()));
        push("illf_f", RT, 6'b000111, 1'b0, 1'b1, 4'd0, o_fetch(1'b1));
        push("illf_d", RT, 6'b000111, 1'b0, 1'b1, 4'd1, with_ill(o_decode()));
        // FETCH timeout: 4 wait cycles, error on the 5th, one-cycle pulse
        for (int i = 0; i < 4; i++)
            push("fto_wait", LW, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch(1'b0));
        push("fto_err", LW, 6'd0, 1'b0, 1'b0, 4'd0, with_err(o_fetch(1'b0)));
        push("fto_after", LW, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch(1'b0));
        // lw with ready arriving exactly at the limit: completes, no error
        fd("lwl", LW, 6'd0);
        push("lwl_adr", LW, 6'd0, 1'b0, 1'b1, 4'd2, o_memadr());
        for (int i = 0; i < 4; i++)
            push("lwl_wait", LW, 6'd0, 1'b0, 1'b0, 4'd3, o_memrd());
        push("lwl_rdy", LW, 6'd0, 1'b0, 1'b1, 4'd3, o_memrd());
        push("lwl_wb",  LW, 6'd0, 1'b0, 1'b1, 4'd4, o_memwb());
        // sw timeout: memwrite dropped in the error cycle
        fd("swt", SW, 6'd0);
        push("swt_adr", SW, 6'd0, 1'b0, 1'b1, 4'd2, o_memadr());
        for (int i = 0; i < 4; i++)
            push("swt_wait", SW, 6'd0, 1'b0, 1'b0, 4'd5, o_memwr(1'b1));
        push("swt_err", SW, 6'd0, 1'b0, 1'b0, 4'd5, with_err(o_memwr(1'b0)));
        // into MEMWR stall for the async reset step
        fd("swr", SW, 6'd0);
        push("swr_adr", SW, 6'd0, 1'b0, 1'b1, 4'd2, o_memadr());
        push("swr_wait", SW, 6'd0, 1'b0, 1'b0, 4'd5, o_memwr(1'b1));
        push("swr_wait", SW, 6'd0, 1'b0, 1'b0, 4'd5, o_memwr(1'b1));
        drain();

        // async reset mid-MEMWR: takes effect without a clock edge
        mem_ready = 1'b0;
        #1;
        check("arst_pre", 4'd5, o_memwr(1'b1));
        #1 reset = 1'b1;
        #1;
        check("arst", 4'd0, o_fetch(1'b0));
        mem_ready = 1'b1;
        #1;
        check("arst_rdy", 4'd0, o_fetch(1'b0));
        @(posedge clk);
        #1;
        check("arst_hold", 4'd0, o_fetch(1'b0));
        @(negedge clk);
        reset = 1'b0;

        // normal operation resumes: add
        fd("add", RT, 6'b100000);
        push("add_ex", RT, 6'b100000, 1'b0, 1'b1, 4'd6, o_exec(A_ADD));
        push("add_wb", RT, 6'b100000, 1'b0, 1'b1, 4'd7, o_aluwb());
        push("end_f", LW, 6'd0, 1'b0, 1'b0, 4'd0, o_fetch(1'b0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
